// File: rtl/time_set_controller_if.sv
// Button inputs and time/display outputs of the time-set controller.
// master drives the raw buttons and observes the display side; slave is the controller.
interface time_set_controller_if;
  logic       btn_mode;
  logic       btn_inc;
  logic [5:0] sec;
  logic [5:0] min;
  logic [1:0] mode;
  logic       blank_min;
  logic       blank_sec;
  logic       sec_tick;

  modport master (
    output btn_mode, btn_inc,
    input  sec, min, mode, blank_min, blank_sec, sec_tick
  );

  modport slave (
    input  btn_mode, btn_inc,
    output sec, min, mode, blank_min, blank_sec, sec_tick
  );
endinterface

// File: rtl/time_set_controller.sv
// MM:SS clock with mode/inc buttons: 2-flop sync + debounce, press pulse 1 edge after a debounced rise.
// Outputs are registered (blanks are an AND of registers); no backpressure, every press is consumed.
module time_set_controller #(
  parameter int TICK_DIV   = 100_000_000,
  parameter int DEB_CYCLES = 1_000_000,
  parameter int BLINK_DIV  = 25_000_000
) (
  input  logic                  CLK100MHZ,
  input  logic                  Resetn,
  time_set_controller_if.slave  bus
);
  localparam logic [1:0] RUN     = 2'b00;
  localparam logic [1:0] SET_MIN = 2'b01;
  localparam logic [1:0] SET_SEC = 2'b10;

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int TW = $clog2(TICK_DIV + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam logic [DW-1:0] DEB_MAX   = DW'(DEB_CYCLES - 1);
  localparam logic [TW-1:0] TICK_MAX  = TW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

  // Bit 0 is the mode button, bit 1 the inc button.
  logic [1:0]         raw, sync1, sync2, deb, deb_d, press;
  logic [1:0][DW-1:0] deb_cnt;

  logic [1:0]    mode_q, mode_nxt;
  logic          in_set_min, in_set_sec;
  logic [TW-1:0] tick_cnt;
  logic          tick_fire, sec_tick_q;
  logic [5:0]    sec_q, min_q;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  logic          mode_press, inc_press, inc_acc, mode_chg;

  assign raw = {bus.btn_inc, bus.btn_mode};

  always_ff @(posedge CLK100MHZ or negedge Resetn) begin
    if (!Resetn) begin
      sync1   <= '0;
      sync2   <= '0;
      deb     <= '0;
      deb_d   <= '0;
      press   <= '0;
      deb_cnt <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_d <= deb;
      press <= deb & ~deb_d;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != deb[i]) begin
          if (deb_cnt[i] == DEB_MAX) begin
            deb[i]     <= sync2[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  // A simultaneous mode press wins and the inc press is dropped.
  assign mode_press = press[0];
  assign inc_press  = press[1] & ~press[0];
  assign inc_acc    = inc_press & (mode_q == SET_MIN || mode_q == SET_SEC);
  assign tick_fire  = (mode_q == RUN) && (tick_cnt == TICK_MAX);

  always_comb begin
    mode_nxt = mode_q;
    if (mode_q == 2'b11) begin
      mode_nxt = RUN;
    end else if (mode_press) begin
      case (mode_q)
        RUN:     mode_nxt = SET_MIN;
        SET_MIN: mode_nxt = SET_SEC;
        default: mode_nxt = RUN;
      endcase
    end
  end

  assign mode_chg = (mode_nxt != mode_q);

  always_ff @(posedge CLK100MHZ or negedge Resetn) begin
    if (!Resetn) begin
      mode_q     <= RUN;
      in_set_min <= 1'b0;
      in_set_sec <= 1'b0;
      tick_cnt   <= '0;
      sec_tick_q <= 1'b0;
    end else begin
      mode_q     <= mode_nxt;
      in_set_min <= (mode_nxt == SET_MIN);
      in_set_sec <= (mode_nxt == SET_SEC);
      if (mode_q != RUN) begin
        tick_cnt   <= '0;
        sec_tick_q <= 1'b0;
      end else if (tick_fire) begin
        tick_cnt   <= '0;
        sec_tick_q <= 1'b1;
      end else begin
        tick_cnt   <= tick_cnt + 1'b1;
        sec_tick_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK100MHZ or negedge Resetn) begin
    if (!Resetn) begin
      sec_q <= '0;
      min_q <= '0;
    end else if (tick_fire) begin
      if (sec_q >= 6'd59) begin
        sec_q <= '0;
        min_q <= (min_q >= 6'd59) ? 6'd0 : min_q + 6'd1;
      end else begin
        sec_q <= sec_q + 6'd1;
      end
    end else if (inc_press && mode_q == SET_MIN) begin
      min_q <= (min_q >= 6'd59) ? 6'd0 : min_q + 6'd1;
    end else if (inc_press && mode_q == SET_SEC) begin
      sec_q <= (sec_q >= 6'd59) ? 6'd0 : sec_q + 6'd1;
    end
  end

  // Any user action restarts the blink so the edited field is visible right away.
  always_ff @(posedge CLK100MHZ or negedge Resetn) begin
    if (!Resetn) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (mode_chg || inc_acc || mode_q == RUN) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_MAX) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign bus.sec       = sec_q;
  assign bus.min       = min_q;
  assign bus.mode      = mode_q;
  assign bus.sec_tick  = sec_tick_q;
  assign bus.blank_min = in_set_min & blink_phase;
  assign bus.blank_sec = in_set_sec & blink_phase;
endmodule

// File: doc/time_set_controller.md
TIME_SET_CONTROLLER -- requirements
Module: time_set_controller

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100_000_000, meaning CLK100MHZ cycles per 1 s tick.
REQ-002 SHALL have parameter DEB_CYCLES, default 1_000_000, meaning consecutive stable cycles required to accept a button change.
REQ-003 SHALL have parameter BLINK_DIV, default 25_000_000, meaning cycles per blink phase toggle.
REQ-004 SHALL have port CLK100MHZ, input, 1 bit: the single clock for all logic.
REQ-005 SHALL have port Resetn, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port btn_mode, input, 1 bit: raw, asynchronous mode button, active-high.
REQ-007 SHALL have port btn_inc, input, 1 bit: raw, asynchronous increment button, active-high.
REQ-008 SHALL have port sec, output, 6 bits: seconds, binary, range 0..59.
REQ-009 SHALL have port min, output, 6 bits: minutes, binary, range 0..59.
REQ-010 SHALL have port mode, output, 2 bits: 00 RUN, 01 SET_MIN, 10 SET_SEC.
REQ-011 SHALL have port blank_min, output, 1 bit: downstream display blanks the minute digits when high.
REQ-012 SHALL have port blank_sec, output, 1 bit: downstream display blanks the second digits when high.
REQ-013 SHALL have port sec_tick, output, 1 bit: one-cycle pulse on each counted second.

Function
REQ-014 SHALL pass each button through a 2-flop synchronizer.
REQ-015 SHALL update a button's debounced state on the edge where the synchronized value has differed from it for DEB_CYCLES consecutive edges; any mismatch-free cycle restarts the count.
REQ-016 SHALL register a one-cycle press pulse one edge after a debounced 0->1 transition; releases produce no pulse.
REQ-017 SHALL, on a mode press, step the FSM RUN->SET_MIN->SET_SEC->RUN; code 11 is unreachable and SHALL recover to RUN on the next edge.
REQ-018 SHALL, in RUN, count the tick counter 0..TICK_DIV-1 and assert sec_tick and wrap to 0 when the count equals TICK_DIV-1.
REQ-019 SHALL hold the tick counter at 0 in SET_MIN and SET_SEC, so the first tick after re-entering RUN occurs TICK_DIV cycles later.
REQ-020 SHALL, on a RUN tick, increment sec; at sec==59, set sec to 0 and increment min; at min==59 and sec==59, set both to 0.
REQ-021 SHALL, in SET_MIN, on an inc press set min to (min==59 ? 0 : min+1), leaving sec unchanged.
REQ-022 SHALL, in SET_SEC, on an inc press set sec to (sec==59 ? 0 : sec+1), with no carry into min.
REQ-023 SHALL ignore inc presses in RUN.
REQ-024 SHALL, when mode and inc presses occur in the same cycle, act on mode only and discard inc.
REQ-025 SHALL, in SET modes, toggle blink_phase every BLINK_DIV cycles; on any mode change or accepted inc, clear blink_phase to 0 and restart the blink counter; in RUN, hold both at 0.
REQ-026 SHALL drive blank_min = (mode==SET_MIN) & blink_phase and blank_sec = (mode==SET_SEC) & blink_phase.
REQ-027 SHALL never let sec or min leave 0..59.
REQ-028 SHALL drive all outputs directly from registers or from the AND of registered terms only.

Reset
REQ-029 SHALL, while Resetn is low, asynchronously force sec=0, min=0, mode=RUN, sec_tick=0, blank_min=0, blank_sec=0.
REQ-030 SHALL, while Resetn is low, asynchronously clear the synchronizers, debounced states, press pulses, tick counter, blink counter and blink_phase.
REQ-031 SHALL, when reset is asserted mid-operation (e.g. in SET_SEC or mid-debounce), discard pending presses and partial counts.
REQ-032 SHALL begin counting on the first edge after Resetn deasserts.

Verification (benches use TICK_DIV=10, DEB_CYCLES=4, BLINK_DIV=5)
REQ-033 SHALL cover: RUN from reset for 600 cycles -> sec_tick pulses at cycles 10,20,...; after 60 ticks, sec=0 and min=1.
REQ-034 SHALL cover: preload min=59, sec=59 via SET modes, return to RUN, wait one tick -> sec=0 and min=0.
REQ-035 SHALL cover: btn_inc glitch lasting 3 cycles -> no press; held 20 cycles -> exactly one press; release -> no press.
REQ-036 SHALL cover: one mode press, then 61 inc presses -> mode=01 and min=1, with sec and the tick counter unchanged.
REQ-037 SHALL cover: in SET_SEC, hold with no presses -> blank_sec toggles every 5 cycles and blank_min=0; an inc press clears blank_sec on the next edge.
REQ-038 SHALL cover: mode and inc press pulses in the same cycle from SET_MIN -> mode=10 and min unchanged; Resetn pulsed low mid-debounce -> all outputs 0 and no press afterwards.
